lns_add_arbiter: RTL and testbench
==================================

Name: lns_add_arbiter

Overview:
- Shares one 18-bit log-domain adder (logAddition_bitshift, bit_size 18, bit_shift 9) among NUM_REQ requesters.
- Round-robin arbitration, 2-stage registered pipeline (operand stage, result stage), valid/ready backpressure on the result side.
- Sits between the LNS processing lanes and the single adder instance; one accepted operation per cycle sustained.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 18, operand/result width; fixed to match the adder's bit_size.
- ID_W, 2, requester index width; equals clog2(NUM_REQ).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held with operands until gnt.
- req_x  input  NUM_REQ*WIDTH  signed log-magnitude X, requester i at [i*WIDTH +: WIDTH].
- req_y  input  NUM_REQ*WIDTH  signed log-magnitude Y, same packing.
- req_sx  input  NUM_REQ  sign of X per requester.
- req_sy  input  NUM_REQ  sign of Y per requester.
- gnt  output  NUM_REQ  one-hot or zero, combinational; req[i]&gnt[i] means operands captured at this edge.
- flush  input  1  synchronous pipeline clear.
- rsp_valid  output  1  result stage holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_z  output  WIDTH  result log-magnitude.
- rsp_sz  output  1  result sign.
- rsp_id  output  ID_W  index of the requester that issued this result.
- busy  output  1  operand stage or result stage occupied.

Behaviour:
- Reset (async, rst_n=0): op_valid=0, rsp_valid=0, rsp_z=0, rsp_sz=0, rsp_id=0, busy=0, rr_ptr=0, gnt=0.
- Stall rules:
  - res_adv = !rsp_valid | rsp_ready.
  - op_adv = !op_valid | res_adv.
  - gnt is nonzero only when op_adv=1, flush=0 and any req is high.
- Arbitration:
  - Search req starting at index rr_ptr, ascending with wrap; grant the first set bit.
  - On a grant to index k, rr_ptr <= (k+1) mod NUM_REQ.
  - rr_ptr is unchanged when nothing is granted.
  - A requester may drop req before gnt; no penalty, no grant.
- Operand stage: on grant, capture x, y, sx, sy, id of the winner and set op_valid=1. If op_adv=1 with no grant, op_valid <= 0.
- Result stage: when res_adv=1 and op_valid=1, load the adder outputs and op id, rsp_valid <= 1. When res_adv=1 and op_valid=0, rsp_valid <= 0.
  - Result holds stable while rsp_valid & !rsp_ready.
- Latency: grant at edge N -> rsp_valid=1 after edge N+1 (visible in cycle N+2), absent stalls. Throughput 1 per cycle.
- Adder function (combinational on operand-stage registers):
  - diff = |X-Y| as unsigned WIDTH; d = diff>>9.
  - dp = 512>>d; dm = -(1536>>d) mod 2^18.
  - Larger operand L = X if signed X>Y, else Y (ties select Y). Sz = sign of L.
  - Z = (L + (Sx==Sy ? dp : dm)) mod 2^18. No saturation; wrap is passed through.
- Flush:
  - Next edge clears op_valid and rsp_valid; no grant in the flush cycle.
  - rr_ptr is kept.
  - The result being dropped by flush is not handshaken, even if rsp_ready=1.
- Simultaneous rsp_ready and new grant with full pipeline: both stages advance in the same edge, no bubble.
- Reset mid-operation: all in-flight results are lost; no rsp_valid after release until a new grant.
- busy = op_valid | rsp_valid.

Test Plan:
- Single op, req[0]=1, X=0x00A00, Y=0x00400, Sx=Sy=0, rsp_ready=1 -> gnt[0] same cycle; two cycles later rsp_valid=1, rsp_z=0x00A40, rsp_sz=0, rsp_id=0.
- Opposite signs, req[2] with X=0x00A00, Sx=0, Y=0x00400, Sy=1 -> rsp_z=0x00940, rsp_sz=0, rsp_id=2.
- Tie case, X=Y=0x00200: Sx=Sy=1 -> rsp_z=0x00400, rsp_sz=1; Sx=0, Sy=1 -> rsp_z=0x3FC00, rsp_sz=1.
- All four req held high for 8 cycles, rsp_ready=1 -> gnt order 0,1,2,3,0,1,2,3; eight results in that rsp_id order, back-to-back.
- Backpressure: rsp_ready=0 with two grants issued -> third req gets no gnt, rsp_z stable; raise rsp_ready -> results drain in order, no loss or duplication.
- flush with both stages full -> next cycle rsp_valid=0, busy=0, rr_ptr unchanged. Async rst_n pulse mid-stream -> all outputs 0 immediately, rr_ptr=0.

Source files
------------

// File: rtl/lns_add_arbiter_if.sv
// ============================================================================
// Module      : lns_add_arbiter_if
// Description : Requester, result and control bundle of the shared LNS adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lns_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 18,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ*WIDTH-1:0] req_y;
    logic [NUM_REQ-1:0]       req_sx;
    logic [NUM_REQ-1:0]       req_sy;
    logic [NUM_REQ-1:0]       gnt;
    logic                     flush;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_z;
    logic                     rsp_sz;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;

    modport master (
        output req, req_x, req_y, req_sx, req_sy, flush, rsp_ready,
        input  gnt, rsp_valid, rsp_z, rsp_sz, rsp_id, busy
    );

    modport slave (
        input  req, req_x, req_y, req_sx, req_sy, flush, rsp_ready,
        output gnt, rsp_valid, rsp_z, rsp_sz, rsp_id, busy
    );
endinterface

`default_nettype wire

// File: rtl/lns_add_arbiter.sv
// ============================================================================
// Module      : lns_add_arbiter
// Description : Round-robin arbiter sharing one 18-bit log-domain adder,
//               two registered stages with valid/ready result backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lns_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 18,
    parameter int ID_W    = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    lns_add_arbiter_if.slave   bus
);
    localparam int               c_BIT_SHIFT = 9;
    localparam logic [WIDTH-1:0] c_DP_BASE   = WIDTH'(512);
    localparam logic [WIDTH-1:0] c_DM_BASE   = WIDTH'(1536);

    // operand stage
    logic             r_op_valid;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_sx;
    logic             r_sy;
    logic [ID_W-1:0]  r_op_id;

    // result stage
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_z;
    logic             r_rsp_sz;
    logic [ID_W-1:0]  r_rsp_id;

    logic [ID_W-1:0]  r_rr_ptr;

    logic             w_res_adv;
    logic             w_op_adv;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic             w_gnt_en;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0] w_x   [NUM_REQ];
    logic [WIDTH-1:0] w_y   [NUM_REQ];
    logic [ID_W-1:0]  w_order [NUM_REQ];

    assign w_res_adv = !r_rsp_valid || bus.rsp_ready;
    assign w_op_adv  = !r_op_valid || w_res_adv;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_x[gi]     = bus.req_x[gi*WIDTH +: WIDTH];
            assign w_y[gi]     = bus.req_y[gi*WIDTH +: WIDTH];
            assign w_order[gi] = ID_W'((int'(r_rr_ptr) + gi) % NUM_REQ);
        end
    endgenerate

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req[w_order[i]]) begin
                w_found = 1'b1;
                w_win   = w_order[i];
            end
        end
    end

    assign w_gnt_en  = rst_n && w_op_adv && !bus.flush && w_found;
    assign w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + ID_W'(1);
    assign bus.gnt   = w_gnt_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win) : '0;

    // Log-domain addition on the operand-stage registers.
    logic signed [WIDTH:0] w_xe;
    logic signed [WIDTH:0] w_ye;
    logic signed [WIDTH:0] w_sub;
    logic        [WIDTH:0] w_abs;
    logic [WIDTH-1:0]      w_diff;
    logic [WIDTH-1:0]      w_d;
    logic [WIDTH-1:0]      w_dp;
    logic [WIDTH-1:0]      w_dm;
    logic                  w_x_gt;
    logic [WIDTH-1:0]      w_l;
    logic                  w_sz;
    logic [WIDTH-1:0]      w_z;

    assign w_xe   = {r_x[WIDTH-1], r_x};
    assign w_ye   = {r_y[WIDTH-1], r_y};
    assign w_sub  = w_xe - w_ye;
    assign w_abs  = w_sub[WIDTH] ? (~w_sub + 1'b1) : w_sub;
    assign w_diff = w_abs[WIDTH-1:0];
    assign w_d    = w_diff >> c_BIT_SHIFT;
    assign w_dp   = c_DP_BASE >> w_d;
    assign w_dm   = '0 - (c_DM_BASE >> w_d);
    // Ties pick Y as the larger operand.
    assign w_x_gt = $signed(r_x) > $signed(r_y);
    assign w_l    = w_x_gt ? r_x : r_y;
    assign w_sz   = w_x_gt ? r_sx : r_sy;
    assign w_z    = w_l + ((r_sx == r_sy) ? w_dp : w_dm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_valid  <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_sx        <= 1'b0;
            r_sy        <= 1'b0;
            r_op_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_z     <= '0;
            r_rsp_sz    <= 1'b0;
            r_rsp_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (bus.flush) begin
            // Drop everything in flight; the arbitration pointer survives.
            r_op_valid  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_op_adv) begin
                r_op_valid <= w_gnt_en;
                if (w_gnt_en) begin
                    r_x     <= w_x[w_win];
                    r_y     <= w_y[w_win];
                    r_sx    <= bus.req_sx[w_win];
                    r_sy    <= bus.req_sy[w_win];
                    r_op_id <= w_win;
                end
            end
            if (w_res_adv) begin
                r_rsp_valid <= r_op_valid;
                if (r_op_valid) begin
                    r_rsp_z  <= w_z;
                    r_rsp_sz <= w_sz;
                    r_rsp_id <= r_op_id;
                end
            end
            if (w_gnt_en) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_z     = r_rsp_z;
    assign bus.rsp_sz    = r_rsp_sz;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = r_op_valid || r_rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_lns_add_arbiter.sv
// ============================================================================
// Module      : tb_lns_add_arbiter
// Description : Directed-vector scoreboard bench for lns_add_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lns_add_arbiter;
    localparam int NR = 4;
    localparam int W  = 18;
    localparam int IW = 2;

    logic clk;
    logic rst_n;

    lns_add_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) bus ();

    lns_add_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  z;
        logic          sz;
        logic [IW-1:0] id;
    } exp_t;

    // Hand-computed vectors: x, y, sx, sy -> z, sz
    logic [W-1:0] vx  [11] = '{18'h00A00, 18'h00A00, 18'h00200, 18'h00200, 18'h00400, 18'h3FC00,
                               18'h01200, 18'h02000, 18'h1FFFF, 18'h1FFFF, 18'h01000};
    logic [W-1:0] vy  [11] = '{18'h00400, 18'h00400, 18'h00200, 18'h00200, 18'h00A00, 18'h00200,
                               18'h00000, 18'h00000, 18'h1FFFF, 18'h20000, 18'h00000};
    logic         vsx [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         vsy [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] vz  [11] = '{18'h00A40, 18'h00940, 18'h00400, 18'h3FC00, 18'h00A40, 18'h00240,
                               18'h011FD, 18'h02000, 18'h201FF, 18'h1FFFF, 18'h01002};
    logic         vsz [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    exp_t         q [$];
    int           slot_v [NR];
    int           errors;
    int           checks;
    logic         hold_req;
    logic [NR-1:0] last_gnt;
    logic         s_rsp_valid;
    logic         s_busy;
    logic [W-1:0] s_rsp_z;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_slot(input int k, input int v);
        slot_v[k]             = v;
        bus.req_x[k*W +: W]   = vx[v];
        bus.req_y[k*W +: W]   = vy[v];
        bus.req_sx[k]         = vsx[v];
        bus.req_sy[k]         = vsy[v];
    endtask

    // One clock: sample at negedge, push expected results for captured
    // operands, then drop the granted requests just after the edge.
    task automatic step();
        logic [NR-1:0] g;
        exp_t e;
        @(negedge clk);
        last_gnt    = bus.gnt;
        s_rsp_valid = bus.rsp_valid;
        s_busy      = bus.busy;
        s_rsp_z     = bus.rsp_z;
        g           = bus.req & bus.gnt;
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                e.z  = vz[slot_v[i]];
                e.sz = vsz[slot_v[i]];
                e.id = IW'(i);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (!hold_req) bus.req = bus.req & ~g;
    endtask

    task automatic issue(input int k, input int v, output int n);
        logic got;
        load_slot(k, v);
        bus.req[k] = 1'b1;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            n++;
            if (last_gnt[k]) got = 1'b1;
        end
        chk("issue_grant", {31'd0, got}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            step();
            if (q.size() == 0 && !s_busy) break;
        end
        chk("drain_empty", {31'd0, (q.size() == 0 && !s_busy)}, 32'd1);
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        hold_req = 1'b0;
        bus.req = '0; bus.req_x = '0; bus.req_y = '0;
        bus.req_sx = '0; bus.req_sy = '0;
        bus.flush = 1'b0; bus.rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) slot_v[i] = 0;
        rst_n = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n && bus.rsp_valid && bus.rsp_ready && !bus.flush) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_z",  {14'd0, bus.rsp_z},  {14'd0, e.z});
                        chk("rsp_sz", {31'd0, bus.rsp_sz}, {31'd0, e.sz});
                        chk("rsp_id", {30'd0, bus.rsp_id}, {30'd0, e.id});
                    end
                end
            end
        join_none

        // Reset state
        #3;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_busy",      {31'd0, bus.busy},      32'd0);
        chk("rst_rsp_z",     {14'd0, bus.rsp_z},     32'd0);
        chk("rst_gnt",       {28'd0, bus.gnt},       32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op with latency
        issue(0, 0, n);
        chk("gnt_same_cycle", n, 1);
        step();
        chk("lat_n1_valid", {31'd0, s_rsp_valid}, 32'd0);
        chk("lat_n1_busy",  {31'd0, s_busy},      32'd1);
        step();
        chk("lat_n2_valid", {31'd0, s_rsp_valid}, 32'd1);

        // Directed vectors incl. ties, d=9, d>=16, signed wrap, diff overflow
        issue(2, 1, n);
        for (int v = 2; v < 11; v++) issue(v % NR, v, n);
        drain();

        // Round robin from a fresh pointer, all requests held
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < NR; k++) load_slot(k, k);
        hold_req = 1'b1;
        bus.req  = '1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c < 8) chk("rr_gnt", {28'd0, last_gnt}, 32'd1 << (c % NR));
            if (c >= 2) chk("rr_b2b_valid", {31'd0, s_rsp_valid}, 32'd1);
            if (c == 7) begin
                bus.req  = '0;
                hold_req = 1'b0;
            end
        end
        drain();

        // Backpressure
        bus.rsp_ready = 1'b0;
        load_slot(0, 4); load_slot(1, 5); load_slot(2, 6);
        bus.req = 4'b0111;
        step(); chk("bp_gnt0", {28'd0, last_gnt}, 32'b0001);
        step(); chk("bp_gnt1", {28'd0, last_gnt}, 32'b0010);
        step(); chk("bp_stall_gnt", {28'd0, last_gnt}, 32'd0);
        chk("bp_hold_z", {14'd0, s_rsp_z}, {14'd0, vz[4]});
        step(); chk("bp_stall_gnt2", {28'd0, last_gnt}, 32'd0);
        chk("bp_hold_z2", {14'd0, s_rsp_z}, {14'd0, vz[4]});
        bus.rsp_ready = 1'b1;
        step(); chk("bp_resume_gnt", {28'd0, last_gnt}, 32'b0100);
        drain();

        // Flush with both stages full
        bus.rsp_ready = 1'b0;
        load_slot(3, 7); load_slot(0, 8);
        bus.req = 4'b1001;
        step(); chk("fl_gnt3", {28'd0, last_gnt}, 32'b1000);
        step(); chk("fl_gnt0", {28'd0, last_gnt}, 32'b0001);
        step(); chk("fl_full_busy", {31'd0, s_busy}, 32'd1);
        bus.flush = 1'b1;
        bus.rsp_ready = 1'b1;
        load_slot(1, 9);
        bus.req[1] = 1'b1;
        step(); chk("fl_no_gnt", {28'd0, last_gnt}, 32'd0);
        bus.flush = 1'b0;
        q.delete();
        step();
        chk("fl_rsp_valid", {31'd0, s_rsp_valid}, 32'd0);
        chk("fl_busy",      {31'd0, s_busy},      32'd0);
        chk("fl_ptr_kept",  {28'd0, last_gnt},    32'b0010);
        drain();

        // Asynchronous reset mid-stream
        bus.rsp_ready = 1'b0;
        load_slot(2, 10); load_slot(1, 0);
        bus.req = 4'b0110;
        step(); chk("rs_gnt2", {28'd0, last_gnt}, 32'b0100);
        step(); chk("rs_gnt1", {28'd0, last_gnt}, 32'b0010);
        load_slot(0, 3); load_slot(3, 2);
        bus.req = 4'b1001;
        #2 rst_n = 1'b0;
        #1;
        chk("rs_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rs_busy",      {31'd0, bus.busy},      32'd0);
        chk("rs_rsp_z",     {14'd0, bus.rsp_z},     32'd0);
        chk("rs_rsp_sz",    {31'd0, bus.rsp_sz},    32'd0);
        chk("rs_rsp_id",    {30'd0, bus.rsp_id},    32'd0);
        chk("rs_gnt",       {28'd0, bus.gnt},       32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        step();
        chk("rs_ptr_zero",   {28'd0, last_gnt},    32'b0001);
        chk("rs_no_valid1",  {31'd0, s_rsp_valid}, 32'd0);
        step();
        chk("rs_gnt3",       {28'd0, last_gnt},    32'b1000);
        chk("rs_no_valid2",  {31'd0, s_rsp_valid}, 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
